// File: rtl/pec_wei_unpack_if.sv
// pec_wei_unpack_if
//   Stream bundle around the sparse-weight unpacker.
//   flag stream   : flg_val / flg_rdy / flg_dat   (one block bitmap per transfer)
//   weight stream : wei_val / wei_rdy / wei_dat   (BEAT_BYTES packed bytes, byte 0 in [7:0])
//   output stream : out_val / out_rdy / out_wei / out_ch / out_kn / out_last
//   done          : one-cycle pulse after a block completes
//   modport slave  = unpacker side, modport master = producer/consumer side.
interface pec_wei_unpack_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_DEPTH = 32,
  parameter int KERNEL_SIZE = 9,
  parameter int BEAT_BYTES  = 8
);
  localparam int FLG_W = BLOCK_DEPTH * KERNEL_SIZE;

  logic                             flg_val;
  logic                             flg_rdy;
  logic [FLG_W-1:0]                 flg_dat;
  logic                             wei_val;
  logic                             wei_rdy;
  logic [DATA_WIDTH*BEAT_BYTES-1:0] wei_dat;
  logic                             out_val;
  logic                             out_rdy;
  logic [DATA_WIDTH-1:0]            out_wei;
  logic [4:0]                       out_ch;
  logic [3:0]                       out_kn;
  logic                             out_last;
  logic                             done;

  modport master (
    output flg_val, flg_dat, wei_val, wei_dat, out_rdy,
    input  flg_rdy, wei_rdy, out_val, out_wei, out_ch, out_kn, out_last, done
  );

  modport slave (
    input  flg_val, flg_dat, wei_val, wei_dat, out_rdy,
    output flg_rdy, wei_rdy, out_val, out_wei, out_ch, out_kn, out_last, done
  );
endinterface

// File: rtl/pec_wei_unpack.sv
// pec_wei_unpack
//   Sparse-weight unpacker at the PEC input. Takes one block flag bitmap and a
//   contiguous stream of packed non-zero weight bytes; for every set flag bit,
//   lowest position first, emits one weight byte tagged with channel
//   (pos % BLOCK_DEPTH) and kernel (pos / BLOCK_DEPTH).
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    pec_wei_unpack_if.slave (flag, weight and output streams, done)
//
//   Build option PECWEI_DENSE_EN: when defined, every flag position is emitted
//   in order; cleared positions output a zero weight without consuming a byte.
//   Default build (undefined) is sparse mode.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a flag word; flg_rdy high
//   RUN   | emitting elements of the current block
module pec_wei_unpack #(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_DEPTH = 32,
  parameter int KERNEL_SIZE = 9,
  parameter int BEAT_BYTES  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  pec_wei_unpack_if.slave bus
);

  localparam int FLG_W     = BLOCK_DEPTH * KERNEL_SIZE;
  localparam int BUF_BYTES = 2 * BEAT_BYTES;
  localparam int CNT_W     = $clog2(BUF_BYTES + 1);
  localparam int POS_W     = $clog2(FLG_W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_nxt;
  logic [FLG_W-1:0]       rem, rem_nxt;
  logic [DATA_WIDTH-1:0]  wbuf     [BUF_BYTES];
  logic [DATA_WIDTH-1:0]  wbuf_nxt [BUF_BYTES];
  logic [DATA_WIDTH-1:0]  shifted  [BUF_BYTES];
  logic [CNT_W-1:0]       cnt, cnt_nxt, base;
  logic                   done_q, done_nxt;

  logic [POS_W-1:0]       sel_pos;
  logic                   sel_flag;   // current position consumes a buffer byte
  logic                   sel_last;   // current position is the block's final element
  logic                   run, has_byte, out_val_i, hs, pop, push;

`ifdef PECWEI_DENSE_EN
  logic [POS_W-1:0]       pos, pos_nxt;

  // Dense mode walks every position; rem keeps the whole bitmap.
  assign sel_pos  = pos;
  assign sel_flag = rem[pos];
  assign sel_last = (pos == POS_W'(FLG_W - 1));
`else
  localparam logic [FLG_W-1:0] ONE = FLG_W'(1);

  // Lowest set bit of rem wins: scan from the top so the last hit is lowest.
  always_comb begin
    sel_pos = '0;
    for (int i = FLG_W - 1; i >= 0; i--) begin
      if (rem[i]) sel_pos = POS_W'(i);
    end
  end

  assign sel_flag = 1'b1;
  // Exactly one bit left: clearing the lowest bit leaves nothing.
  assign sel_last = (rem != '0) && ((rem & (rem - ONE)) == '0);
`endif

  assign run       = (state == RUN);
  assign has_byte  = (cnt != '0);
  assign out_val_i = run && (sel_flag ? has_byte : 1'b1);
  assign hs        = out_val_i && bus.out_rdy;
  assign pop       = hs && sel_flag;
  assign push      = bus.wei_val && bus.wei_rdy;

  assign bus.flg_rdy  = (state == IDLE);
  assign bus.wei_rdy  = (cnt <= CNT_W'(BUF_BYTES - BEAT_BYTES));
  assign bus.out_val  = out_val_i;
  assign bus.out_wei  = (run && !sel_flag) ? '0 : wbuf[0];
  assign bus.out_ch   = run ? 5'(sel_pos % POS_W'(BLOCK_DEPTH)) : 5'd0;
  assign bus.out_kn   = run ? 4'(sel_pos / POS_W'(BLOCK_DEPTH)) : 4'd0;
  assign bus.out_last = run && sel_last;
  assign bus.done     = done_q;

  // Weight buffer: shift out byte 0 on pop, then append the new beat at the
  // post-shift fill level. wei_rdy caps cnt at BUF_BYTES-BEAT_BYTES before a
  // push, so the append never runs past the end.
  always_comb begin
    for (int j = 0; j < BUF_BYTES - 1; j++) begin
      shifted[j] = pop ? wbuf[j+1] : wbuf[j];
    end
    shifted[BUF_BYTES-1] = pop ? '0 : wbuf[BUF_BYTES-1];

    base = pop ? (cnt - CNT_W'(1)) : cnt;

    for (int j = 0; j < BUF_BYTES; j++) begin
      wbuf_nxt[j] = shifted[j];
      if (push) begin
        for (int k = 0; k < BEAT_BYTES; k++) begin
          if (CNT_W'(j) == base + CNT_W'(k)) begin
            wbuf_nxt[j] = bus.wei_dat[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end

    cnt_nxt = base + (push ? CNT_W'(BEAT_BYTES) : CNT_W'(0));
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    done_nxt  = 1'b0;
`ifdef PECWEI_DENSE_EN
    pos_nxt   = pos;
`endif
    case (state)
      IDLE: begin
        if (bus.flg_val) begin
          rem_nxt = bus.flg_dat;
`ifdef PECWEI_DENSE_EN
          pos_nxt   = '0;
          state_nxt = RUN;
`else
          // An empty bitmap has nothing to emit: finish the block immediately.
          if (bus.flg_dat != '0) state_nxt = RUN;
          else                   done_nxt  = 1'b1;
`endif
        end
      end
      RUN: begin
        if (hs) begin
`ifdef PECWEI_DENSE_EN
          pos_nxt = pos + POS_W'(1);
`else
          rem_nxt = rem & (rem - ONE);
`endif
          if (sel_last) begin
            state_nxt = IDLE;
            rem_nxt   = '0;
            done_nxt  = 1'b1;
`ifdef PECWEI_DENSE_EN
            pos_nxt   = '0;
`endif
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rem    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      for (int j = 0; j < BUF_BYTES; j++) wbuf[j] <= '0;
`ifdef PECWEI_DENSE_EN
      pos    <= '0;
`endif
    end else begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      cnt    <= cnt_nxt;
      done_q <= done_nxt;
      for (int j = 0; j < BUF_BYTES; j++) wbuf[j] <= wbuf_nxt[j];
`ifdef PECWEI_DENSE_EN
      pos    <= pos_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_pec_wei_unpack.sv
// tb_pec_wei_unpack
//   Directed bench for pec_wei_unpack (sparse build). A negedge monitor keeps
//   a scoreboard: accepted flag words push expected (position, last) entries,
//   accepted beats push expected bytes; each output handshake pops and checks
//   both, and the done pulse is predicted one cycle ahead.
module tb_pec_wei_unpack;
  localparam int FLG_W = 288;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pec_wei_unpack_if bus ();
  pec_wei_unpack dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int errs    = 0;

  logic [7:0] byte_q [$];
  logic [9:0] pos_q  [$];   // {last, position}

  int   cyc      = 0;
  int   hs_total = 0;
  int   first_hs = -1;
  int   last_hs  = -1;
  logic exp_done = 1'b0;
  logic nd;
  logic [9:0] e;
  logic [7:0] b;
  int   hi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      byte_q.delete();
      pos_q.delete();
      exp_done = 1'b0;
    end else begin
      check("done", 32'(bus.done), 32'(exp_done));
      nd = 1'b0;
      if (bus.out_val) begin
        check("out_val_expected", 32'(pos_q.size() != 0 && byte_q.size() != 0), 1);
        if (bus.out_rdy && pos_q.size() != 0 && byte_q.size() != 0) begin
          e = pos_q.pop_front();
          b = byte_q.pop_front();
          check("out_wei",  32'(bus.out_wei),  32'(b));
          check("out_ch",   32'(bus.out_ch),   32'(e[8:0] % 32));
          check("out_kn",   32'(bus.out_kn),   32'(e[8:0] / 32));
          check("out_last", 32'(bus.out_last), 32'(e[9]));
          nd = e[9];
          hs_total++;
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
        end
      end
      if (bus.flg_val && bus.flg_rdy) begin
        if (bus.flg_dat == '0) nd = 1'b1;
        else begin
          hi = -1;
          for (int p = 0; p < FLG_W; p++) if (bus.flg_dat[p]) hi = p;
          for (int p = 0; p < FLG_W; p++)
            if (bus.flg_dat[p]) pos_q.push_back({(p == hi), 9'(p)});
        end
      end
      if (bus.wei_val && bus.wei_rdy)
        for (int k = 0; k < 8; k++) byte_q.push_back(bus.wei_dat[k*8 +: 8]);
      exp_done = nd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_flags(input logic [FLG_W-1:0] f);
    int n = 0;
    while (!bus.flg_rdy && n < 200) begin tick(); n++; end
    check("flg_rdy_wait", 32'(bus.flg_rdy), 1);
    bus.flg_val = 1'b1;
    bus.flg_dat = f;
    tick();
    bus.flg_val = 1'b0;
    bus.flg_dat = '0;
  endtask

  task automatic send_beat(input logic [63:0] d);
    int n = 0;
    while (!bus.wei_rdy && n < 200) begin tick(); n++; end
    check("wei_rdy_wait", 32'(bus.wei_rdy), 1);
    bus.wei_val = 1'b1;
    bus.wei_dat = d;
    tick();
    bus.wei_val = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (pos_q.size() != 0 && n < 3000) begin tick(); n++; end
    check("drain", pos_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_flg_rdy"},  32'(bus.flg_rdy),  1);
    check({tag, "_wei_rdy"},  32'(bus.wei_rdy),  1);
    check({tag, "_out_val"},  32'(bus.out_val),  0);
    check({tag, "_out_wei"},  32'(bus.out_wei),  0);
    check({tag, "_out_ch"},   32'(bus.out_ch),   0);
    check({tag, "_out_kn"},   32'(bus.out_kn),   0);
    check({tag, "_out_last"}, 32'(bus.out_last), 0);
    check({tag, "_done"},     32'(bus.done),     0);
  endtask

  function automatic logic [63:0] mk_beat(input int s);
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[k*8 +: 8] = 8'(s * 8 + k + 'h30);
    return d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FLG_W-1:0] f;
    int sent, hs_base;

    rst_n       = 1'b0;
    bus.flg_val = 1'b0;
    bus.flg_dat = '0;
    bus.wei_val = 1'b0;
    bus.wei_dat = '0;
    bus.out_rdy = 1'b1;
    tick();
    tick();
    check_reset("rst");
    rst_n = 1'b1;
    tick();

    // block with bits {0,33,287}
    send_beat(64'h0807060504030201);
    f = '0; f[0] = 1'b1; f[33] = 1'b1; f[287] = 1'b1;
    send_flags(f);
    drain();

    // carried-over bytes feed the next block
    f = '0; f[5] = 1'b1; f[6] = 1'b1;
    send_flags(f);
    drain();

    // empty bitmap
    send_flags('0);
    check("zero_done",    32'(bus.done),    1);
    check("zero_flg_rdy", 32'(bus.flg_rdy), 1);
    check("zero_out_val", 32'(bus.out_val), 0);
    tick();
    check("zero_done_clr", 32'(bus.done), 0);

    // stall with a full buffer (3 leftover + 16 new bytes, 19 flags)
    bus.out_rdy = 1'b0;
    f = '0;
    for (int i = 0; i < 19; i++) f[i*15] = 1'b1;
    send_flags(f);
    send_beat(64'hA7A6A5A4A3A2A1A0);
    bus.out_rdy = 1'b1;
    repeat (3) tick();
    bus.out_rdy = 1'b0;
    check("stall_wei_rdy_pre", 32'(bus.wei_rdy), 1);
    send_beat(64'hB7B6B5B4B3B2B1B0);
    for (int i = 0; i < 5; i++) begin
      check("stall_wei_rdy", 32'(bus.wei_rdy), 0);
      check("stall_out_val", 32'(bus.out_val), 1);
      check("stall_out_wei", 32'(bus.out_wei), 32'(byte_q[0]));
      check("stall_out_ch",  32'(bus.out_ch),  32'(pos_q[0][8:0] % 32));
      check("stall_out_kn",  32'(bus.out_kn),  32'(pos_q[0][8:0] / 32));
      tick();
    end
    bus.out_rdy = 1'b1;
    drain();
    check("stall_wei_rdy_post", 32'(bus.wei_rdy), 1);

    // full bitmap with a continuous beat stream
    hs_base  = hs_total;
    first_hs = -1;
    sent     = 0;
    bus.flg_val = 1'b1;
    bus.flg_dat = '1;
    for (int c = 0; c < 340; c++) begin
      if (sent < 36 && bus.wei_rdy) begin
        bus.wei_val = 1'b1;
        bus.wei_dat = mk_beat(sent);
        sent++;
      end else begin
        bus.wei_val = 1'b0;
      end
      tick();
      bus.flg_val = 1'b0;
      bus.flg_dat = '0;
    end
    bus.wei_val = 1'b0;
    check("full_count",  hs_total - hs_base, 288);
    check("full_span",   last_hs - first_hs, 287);
    check("full_beats",  sent, 36);
    check("full_remain", pos_q.size(), 0);

    // reset in the middle of a block
    bus.out_rdy = 1'b0;
    f = '0; f[2] = 1'b1; f[9] = 1'b1; f[50] = 1'b1;
    send_flags(f);
    send_beat(64'hC7C6C5C4C3C2C1C0);
    check("pre_rst_out_val", 32'(bus.out_val), 1);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    bus.out_rdy = 1'b1;
    send_beat(64'h8877665544332211);
    f = '0; f[7] = 1'b1; f[8] = 1'b1; f[100] = 1'b1;
    send_flags(f);
    drain();
    check("post_rst_hs", pos_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
